// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data memory responder: opcodes,
// FSM state encodings and the wait-counter type.
package data_mem_responder_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Wide enough for the largest legal wait latency (7).
    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ONE = cnt_t'(1);

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_ram.sv
// Single-port synchronous word RAM with registered read (read-before-write).
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Array write and registered read port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one aligned access, stalls the
// pipeline for LAT wait cycles, then signals completion for one cycle.
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        halt,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign
);

    import data_mem_responder_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               misalign_q, misalign_d;

    logic               req_s;
    logic               accept_s;
    logic               stall_s;
    logic [IDX_W-1:0]   addr_idx_s;
    logic               addr_unused_s;
    logic               ram_we_s;
    logic [IDX_W-1:0]   ram_addr_s;
    logic [31:0]        ram_rdata_s;

    // Upper address bits fall outside the array and simply wrap.
    assign addr_idx_s    = addr[IDX_W+1:2];
    assign addr_unused_s = &{1'b0, addr[31:IDX_W+2]};
    assign req_s         = memRead | memWrite;

    // Next-state, datapath latching and pipeline stall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        misalign_d = misalign_q;
        accept_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = idx_q;

        case (state_q)
            ST_IDLE: begin
                // Present the incoming index so a LAT=1 access has data ready.
                ram_addr_s = addr_idx_s;
                if (req_s && !halt) begin
                    if (word_aligned(addr[1:0])) begin
                        accept_s = 1'b1;
                        op_d     = memWrite ? OP_WRITE : OP_READ;
                        idx_d    = addr_idx_s;
                        wdata_d  = wdata;
                        cnt_d    = cnt_t'(LAT);
                        state_d  = ST_WAIT;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    if (op_q == OP_READ) begin
                        rdata_d = ram_rdata_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                ram_we_s = (op_q == OP_WRITE) && !reset;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_s = accept_s || (state_q == ST_WAIT);
    end

    // State register, latched access fields and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= OP_READ;
            idx_q      <= {IDX_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_q),
        .rdata (ram_rdata_s)
    );

    assign rdata    = rdata_q;
    assign stall    = stall_s;
    assign done     = done_q;
    assign misalign = misalign_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LAT, default 2, meaning wait cycles per access (legal range 1..7).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port memRead  input  1  read request from the MEM stage.
REQ-006 SHALL have port memWrite  input  1  write request from the MEM stage.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port halt  input  1  end-of-program; blocks new accesses.
REQ-010 SHALL have port rdata  output  32  registered load data.
REQ-011 SHALL have port stall  output  1  freeze request to the pipeline.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port misalign  output  1  sticky alignment-error flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL, in IDLE with (memRead|memWrite)=1, addr[1:0]=0, halt=0, accept the access in that cycle T: latch op, word index, wdata; load counter with LAT; go to WAIT.
REQ-016 SHALL drive stall combinationally: 1 in IDLE during an accepting cycle, 1 throughout WAIT, 0 in RESP and otherwise.
REQ-017 SHALL stay in WAIT for exactly LAT cycles (T+1..T+LAT), decrementing the counter each cycle, then enter RESP at T+LAT+1.
REQ-018 SHALL, in RESP, pulse done=1 for one cycle, then return to IDLE unconditionally; requests present during RESP are ignored (same instruction).
REQ-019 SHALL, for a read, present RAM[index] on rdata in the RESP cycle and hold it until the next read's RESP.
REQ-020 SHALL, for a write, commit wdata to RAM at the end of the RESP cycle; rdata unchanged.
REQ-021 SHALL treat memRead=memWrite=1 as a write; rdata unchanged.
REQ-022 SHALL derive index from addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around).
REQ-023 SHALL, in IDLE with request and addr[1:0]!=0, perform no access, keep stall=0, done=0, and set misalign=1 until reset.
REQ-024 SHALL, with halt=1 in IDLE, accept nothing (stall=0); an access already in WAIT/RESP completes normally.
REQ-025 SHALL ignore memRead/memWrite/addr/wdata changes while in WAIT (latched values used).

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state IDLE, counter 0, rdata 0, done 0, misalign 0; stall follows REQ-016 (0 in IDLE without request).
REQ-027 SHALL abort an in-flight access on reset; a write reset before its RESP edge is not committed.
REQ-028 SHALL NOT clear RAM contents on reset.

Structure
REQ-029 SHALL place FSM state encodings and LAT counter width in the shared header alongside the opcode definitions.
REQ-030 SHALL instantiate one sub-module dmem_ram: single-port synchronous RAM, DEPTH x 32, write enable, registered read.

Verification
REQ-031 SHALL cover: LAT=2, write 0xDEADBEEF to 0x10 at T -> stall=1 T..T+2, done=1 at T+3, stall=0 at T+3.
REQ-032 SHALL cover: read 0x10 after REQ-031 -> rdata=0xDEADBEEF with done at T+3, held afterwards.
REQ-033 SHALL cover: read addr 0x13 -> no stall, no done, misalign=1 and stays 1 until reset.
REQ-034 SHALL cover: DEPTH=256, write 0x55 to 0x400, read 0x000 -> rdata=0x55 (wrap).
REQ-035 SHALL cover: reset asserted at T+1 of a write 0x1234 to 0x20 -> IDLE, stall=0 next cycle; later read 0x20 returns prior contents, not 0x1234.
REQ-036 SHALL cover: halt=1 with memRead=1 in IDLE -> stall=0, done never asserted; halt raised during WAIT -> access still completes with done.
